// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a show-ahead FIFO and serialises them (start, DBIT data LSB first, stop).
// Latency: pop in the IDLE cycle, start bit drives tx on the next clk; tx_done_tick on the final stop s_tick.
// Backpressure: pops only when idle, tx_en=1 and the FIFO is non-empty; tx_en=0 lets the current frame finish.
module uart_tx_fifo_reader #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_en,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [4:0] S_LAST  = 5'd15;
    localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

    state_t          state;
    logic [4:0]      s;
    logic [2:0]      n;
    logic [DBIT-1:0] b;
    logic            tx_reg;

    // Pop strobe, completion pulse and busy flag decoded from the current state; reset masks them all.
    always_comb begin
        rd           = !reset && (state == IDLE) && tx_en && !empty;
        tx_done_tick = !reset && (state == STOP) && s_tick && (s == SB_LAST);
        tx_busy      = (state != IDLE) || rd;
        tx           = tx_reg;
    end

    // Frame sequencer; tx_reg is loaded with the line level of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tx_reg <= 1'b1;
            s      <= '0;
            n      <= '0;
            b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (rd) begin
                        b      <= r_data;
                        s      <= '0;
                        state  <= START;
                        tx_reg <= 1'b0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s      <= '0;
                            n      <= '0;
                            state  <= DATA;
                            tx_reg <= b[0];
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= b >> 1;
                            if (n == N_LAST) begin
                                state  <= STOP;
                                tx_reg <= 1'b1;
                            end else begin
                                n      <= n + 3'd1;
                                tx_reg <= b[1];
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == SB_LAST) begin
                            state <= IDLE;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: two instances (8 data/16 stop ticks and 7 data/32 stop ticks) fed from bench FIFOs.
// Expected outputs come from a tick-count frame model; literal timing checks pin the model to known frames.
// Shared clk, reset, s_tick and tx_en; each instance has its own FIFO queue.
module tb_uart_tx_fifo_reader;

    logic       clk = 1'b0;
    logic       reset, s_tick, tx_en;
    logic       empty0, empty1;
    logic [7:0] rdata0;
    logic [6:0] rdata1;
    logic       rd0, tx0, busy0, done0;
    logic       rd1, tx1, busy1, done1;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_en(tx_en), .empty(empty0), .r_data(rdata0),
        .rd(rd0), .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0));

    uart_tx_fifo_reader #(.DBIT(7), .SB_TICK(32)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_en(tx_en), .empty(empty1), .r_data(rdata1),
        .rd(rd1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tcnt = 0;
    bit chk_en = 0;

    // bench FIFOs and frame model state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         DB [2] = '{8, 7};
    int         SB [2] = '{16, 32};
    bit         act [2];
    int         k [2];
    logic [7:0] byt [2];

    // observations
    logic d_rd [2], d_tx [2], d_busy [2], d_done [2];
    int   pop_cnt [2], done_cnt [2], last_pop [2], last_done [2];
    int   pops0[$];
    int   dones0[$];
    int   low_cnt;
    logic tx_hist0 [8192];
    logic tx_hist1 [8192];

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    function automatic bit f_empty(input int i);
        return (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    endfunction

    function automatic int frame_last(input int i);
        return 16 + 16 * DB[i] + SB[i] - 1;
    endfunction

    function automatic int exp_tx(input int i);
        if (!act[i]) return 1;
        if (k[i] < 16) return 0;
        if (k[i] < 16 + 16 * DB[i]) return int'(byt[i][(k[i] - 16) / 16]);
        return 1;
    endfunction

    function automatic int exp_rd(input int i);
        return int'(!reset && !act[i] && tx_en && !f_empty(i));
    endfunction

    function automatic int exp_done(input int i);
        return int'(!reset && act[i] && s_tick && (k[i] == frame_last(i)));
    endfunction

    function automatic int exp_busy(input int i);
        return int'(act[i] || (exp_rd(i) != 0));
    endfunction

    function automatic logic hist(input int i, input int c);
        return (i == 0) ? tx_hist0[c & 8191] : tx_hist1[c & 8191];
    endfunction

    task automatic fifo_drive();
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
        rdata0 = empty0 ? 8'h00 : q0[0];
        rdata1 = empty1 ? 7'h00 : q1[0][6:0];
    endtask

    task automatic push(input int i, input logic [7:0] v);
        if (i == 0) q0.push_back(v);
        else q1.push_back(v & 8'h7F);
        fifo_drive();
    endtask

    task automatic model_update(input int i);
        bit pop, dn;
        pop = exp_rd(i) != 0;
        dn  = exp_done(i) != 0;
        if (reset) begin
            act[i] = 0;
        end else if (pop) begin
            act[i] = 1;
            k[i]   = 0;
            if (i == 0) byt[i] = q0.pop_front();
            else        byt[i] = q1.pop_front();
        end else if (act[i] && s_tick) begin
            if (dn) act[i] = 0;
            else    k[i]   = k[i] + 1;
        end
    endtask

    // one clock: compare on the falling edge, advance the model on the rising edge
    task automatic cycle();
        @(negedge clk);
        d_rd[0] = rd0;  d_tx[0] = tx0;  d_busy[0] = busy0;  d_done[0] = done0;
        d_rd[1] = rd1;  d_tx[1] = tx1;  d_busy[1] = busy1;  d_done[1] = done1;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rd%0d", i),   int'(d_rd[i]),   exp_rd(i));
                chk($sformatf("tx%0d", i),   int'(d_tx[i]),   exp_tx(i));
                chk($sformatf("busy%0d", i), int'(d_busy[i]), exp_busy(i));
                chk($sformatf("done%0d", i), int'(d_done[i]), exp_done(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (d_rd[i] === 1'b1) begin pop_cnt[i]++; last_pop[i] = cyc; if (i == 0) pops0.push_back(cyc); end
            if (d_done[i] === 1'b1) begin done_cnt[i]++; last_done[i] = cyc; if (i == 0) dones0.push_back(cyc); end
        end
        if (d_tx[0] !== 1'b1 || d_tx[1] !== 1'b1) low_cnt++;
        tx_hist0[cyc & 8191] = d_tx[0];
        tx_hist1[cyc & 8191] = d_tx[1];
        @(posedge clk);
        model_update(0);
        model_update(1);
        cyc++;
        #1;
        fifo_drive();
    endtask

    // n cycles with s_tick every per-th cycle (per<=1: every cycle)
    task automatic step(input int n, input int per);
        for (int j = 0; j < n; j++) begin
            s_tick = (per <= 1) ? 1'b1 : ((tcnt % per) == per - 1);
            tcnt++;
            cycle();
        end
    endtask

    task automatic wait_pop(input int pc);
        for (int j = 0; j < 10 && pop_cnt[0] == pc; j++) step(1, 1);
        chk("pop_within_bound", pop_cnt[0], pc + 1);
    endtask

    initial begin
        int pc, dc, r, p;
        logic [7:0] a5;
        reset = 1'b1; tx_en = 1'b1; s_tick = 1'b0;
        fifo_drive();
        cycle();
        chk_en = 1;
        cycle();
        chk("reset_tx0", int'(d_tx[0]), 1);
        chk("reset_rd0", int'(d_rd[0]), 0);
        chk("reset_busy0", int'(d_busy[0]), 0);
        chk("reset_done1", int'(d_done[1]), 0);
        reset = 1'b0;

        // idle line with empty FIFO and ticks every cycle
        low_cnt = 0;
        step(200, 1);
        chk("idle_pops", pop_cnt[0] + pop_cnt[1], 0);
        chk("idle_low_cycles", low_cnt, 0);

        // 0xA5 on the 8/16 instance, 0x00 on the 7/32 instance
        push(0, 8'hA5);
        push(1, 8'h00);
        step(200, 1);
        chk("a5_pops", pop_cnt[0], 1);
        chk("a5_frame_len", last_done[0] - last_pop[0], 160);
        chk("a5_start", int'(hist(0, last_pop[0] + 9)), 0);
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++)
            chk($sformatf("a5_bit%0d", i), int'(hist(0, last_pop[0] + 17 + 16 * i + 8)), int'(a5[i]));
        chk("a5_stop", int'(hist(0, last_pop[0] + 153)), 1);
        chk("d7_frame_len", last_done[1] - last_pop[1], 160);
        chk("d7_last_data", int'(hist(1, last_pop[1] + 128)), 0);
        chk("d7_first_stop", int'(hist(1, last_pop[1] + 129)), 1);
        pc = 0;
        for (int c = last_pop[1] + 1; c <= last_done[1]; c++) if (hist(1, c) == 1'b1) pc++;
        chk("d7_stop_cycles", pc, 32);

        // two back-to-back frames with s_tick every 4th cycle
        pops0.delete(); dones0.delete();
        push(0, 8'h3C); push(0, 8'hFF);
        tcnt = 0;
        step(1600, 4);
        chk("b2b_pops", pops0.size(), 2);
        chk("b2b_dones", dones0.size(), 2);
        if (pops0.size() == 2 && dones0.size() == 2) begin
            chk("b2b_pop_gap", pops0[1] - dones0[0], 1);
            chk("b2b_frame_gap", dones0[1] - dones0[0], 640);
            chk("b2b_start_bit", int'(hist(0, dones0[0] + 2)), 0);
        end

        // tx_en low holds off pops; dropping it mid-frame finishes the frame only
        tx_en = 1'b0;
        push(0, 8'h11);
        pc = pop_cnt[0];
        low_cnt = 0;
        step(100, 1);
        chk("hold_pops", pop_cnt[0], pc);
        chk("hold_low_cycles", low_cnt, 0);
        push(0, 8'h5A);
        tx_en = 1'b1;
        wait_pop(pc);
        p = last_pop[0];
        step(70, 1);
        tx_en = 1'b0;
        dc = done_cnt[0];
        step(200, 1);
        chk("txen_pops", pop_cnt[0], pc + 1);
        chk("txen_dones", done_cnt[0], dc + 1);
        chk("txen_bit4", int'(hist(0, p + 17 + 64 + 8)), 1);

        // reset during data bit 4, then the next byte pops right after
        push(0, 8'hC3);
        tx_en = 1'b1;
        pc = pop_cnt[0];
        wait_pop(pc);
        step(84, 1);
        reset = 1'b1;
        r = cyc;
        step(1, 1);
        reset = 1'b0;
        step(3, 1);
        chk("rst_tx_after", int'(hist(0, r + 1)), 1);
        chk("rst_repop_cyc", last_pop[0], r + 1);
        chk("rst_pops", pop_cnt[0], pc + 2);
        step(200, 1);

        // randomized traffic
        for (int j = 0; j < 8000; j++) begin
            s_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
            if (q0.size() < 3 && $urandom_range(0, 49) == 0) push(0, 8'($urandom));
            if (q1.size() < 3 && $urandom_range(0, 49) == 0) push(1, 8'($urandom));
            reset = ($urandom_range(0, 2999) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
